// File: rtl/uart_tx_arbiter_if.sv
//----------------------------------------------------------------------------
// Module      : uart_tx_arbiter_if
// Description : Requester and uart_tx handshake bundle for uart_tx_arbiter.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface uart_tx_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_LENGTH = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*DATA_LENGTH-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           tx_start;
    logic [DATA_LENGTH-1:0]         tx_data;
    logic                           tx_busy;
    logic [ID_W-1:0]                grant_id;
    logic                           grant_valid;
    logic                           timeout_err;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_start, tx_data, grant_id, grant_valid, timeout_err
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_start, tx_data, grant_id, grant_valid, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//----------------------------------------------------------------------------
// Module      : uart_tx_arbiter
// Description : Round-robin sharing of one uart_tx serializer among NUM_REQ
//               requesters, with start timeout and optional inter-frame gap.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_LENGTH   = 8,
    parameter int GAP_CYCLES    = 0,
    parameter int START_TIMEOUT = 16
) (
    input  logic              sysclk,
    input  logic              reset,
    uart_tx_arbiter_if.master bus
);
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W   = ID_W + 1;
    localparam int CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [ID_W-1:0]        r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0]     r_req_ready, w_req_ready_nxt;
    logic                   r_tx_start, w_tx_start_nxt;
    logic [DATA_LENGTH-1:0] r_tx_data, w_tx_data_nxt;
    logic [ID_W-1:0]        r_grant_id, w_grant_id_nxt;
    logic                   r_grant_valid, w_grant_valid_nxt;
    logic                   r_timeout_err, w_timeout_err_nxt;
    logic [ID_W-1:0]        w_win;
    logic                   w_win_found;

    // First requesting index at or after the pointer, wrapping modulo NUM_REQ
    always_comb begin
        logic [SUM_W-1:0] idx;
        w_win       = '0;
        w_win_found = 1'b0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, r_ptr} + SUM_W'(k);
            if (idx >= SUM_W'(NUM_REQ)) begin
                idx = idx - SUM_W'(NUM_REQ);
            end
            if (!w_win_found && bus.req_valid[idx[ID_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win       = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_cnt_nxt         = r_cnt;
        w_req_ready_nxt   = '0;
        w_tx_start_nxt    = 1'b0;
        w_tx_data_nxt     = r_tx_data;
        w_grant_id_nxt    = r_grant_id;
        w_grant_valid_nxt = r_grant_valid;
        w_timeout_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_found) begin
                    w_state_nxt       = START;
                    w_tx_start_nxt    = 1'b1;
                    w_req_ready_nxt   = NUM_REQ'(1) << w_win;
                    w_tx_data_nxt     = bus.req_data[w_win*DATA_LENGTH +: DATA_LENGTH];
                    w_grant_id_nxt    = w_win;
                    w_grant_valid_nxt = 1'b1;
                    w_ptr_nxt         = (w_win == LAST_ID) ? '0 : w_win + ID_W'(1);
                end
            end
            START: begin
                w_state_nxt = WAIT_BUSY;
                w_cnt_nxt   = '0;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_cnt == TMO_LAST) begin
                    w_timeout_err_nxt = 1'b1;
                    w_grant_valid_nxt = 1'b0;
                    w_cnt_nxt         = '0;
                    w_state_nxt       = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    w_grant_valid_nxt = 1'b0;
                    w_cnt_nxt         = '0;
                    w_state_nxt       = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_req_ready   <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_tx_start    <= w_tx_start_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.tx_start    = r_tx_start;
    assign bus.tx_data     = r_tx_data;
    assign bus.grant_id    = r_grant_id;
    assign bus.grant_valid = r_grant_valid;
    assign bus.timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//----------------------------------------------------------------------------
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter with a uart_tx stand-in.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;
    localparam int NR  = 4;
    localparam int DL  = 8;
    localparam int GAP = 5;
    localparam int TMO = 16;

    logic sysclk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [NR-1:0] v_now, v_prev;
    logic [DL-1:0] d_now  [NR];
    logic [DL-1:0] d_prev [NR];
    int            mptr;
    int            ready_at;
    logic [DL-1:0] txd;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_LENGTH(DL)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_LENGTH(DL), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)
    ) dut (
        .sysclk(sysclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 sysclk = ~sysclk;

    // uart_tx stand-in: busy for busy_len cycles after each accepted start
    int busy_len = 10;
    bit busy_en  = 1'b1;
    int busy_cnt = 0;
    always @(posedge sysclk) begin
        if (bus.tx_start && busy_en) busy_cnt <= busy_len;
        else if (busy_cnt > 0)       busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt != 0);

    function automatic int rr_pick(int ptr, logic [NR-1:0] v);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic tick();
        bus.req_valid = v_now;
        for (int i = 0; i < NR; i++) bus.req_data[i*DL +: DL] = d_now[i];
        v_prev = v_now;
        d_prev = d_now;
        @(posedge sysclk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        int n;
        reset = 1'b1;
        tick();
        tick();
        n = 0;
        while (bus.tx_busy && n < 1000) begin tick(); n++; end
        reset    = 1'b0;
        mptr     = 0;
        txd      = '0;
        ready_at = cyc + 1;
    endtask

    task automatic test_reset();
        v_now = '1;
        for (int i = 0; i < NR; i++) d_now[i] = DL'($urandom);
        reset = 1'b1;
        tick();
        tick();
        total++; if (bus.tx_start !== 1'b0)    begin bad++; $display("FAIL reset_tx_start got=%b want=0", bus.tx_start); end
        total++; if (bus.req_ready !== '0)     begin bad++; $display("FAIL reset_req_ready got=%b want=0", bus.req_ready); end
        total++; if (bus.tx_data !== '0)       begin bad++; $display("FAIL reset_tx_data got=%h want=0", bus.tx_data); end
        total++; if (bus.grant_id !== '0)      begin bad++; $display("FAIL reset_grant_id got=%0d want=0", bus.grant_id); end
        total++; if (bus.grant_valid !== 1'b0) begin bad++; $display("FAIL reset_grant_valid got=%b want=0", bus.grant_valid); end
        total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b want=0", bus.timeout_err); end
        v_now = '0;
    endtask

    task automatic test_single();
        int s;
        busy_en = 1'b1; busy_len = 6; v_now = '0;
        do_reset();
        for (int i = 0; i < NR; i++) d_now[i] = DL'($urandom);
        d_now[2] = 8'hA5;
        v_now    = 4'b0100;
        tick();
        total++; if (bus.tx_start !== 1'b1)     begin bad++; $display("FAIL single_tx_start got=%b want=1", bus.tx_start); end
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_req_ready got=%b want=0100", bus.req_ready); end
        total++; if (bus.tx_data !== 8'hA5)     begin bad++; $display("FAIL single_tx_data got=%h want=a5", bus.tx_data); end
        total++; if (bus.grant_id !== 2'd2)     begin bad++; $display("FAIL single_grant_id got=%0d want=2", bus.grant_id); end
        total++; if (bus.grant_valid !== 1'b1)  begin bad++; $display("FAIL single_grant_valid got=%b want=1", bus.grant_valid); end
        s     = cyc;
        v_now = '0;
        tick();
        total++; if (bus.tx_start !== 1'b0)  begin bad++; $display("FAIL single_start_width got=%b want=0", bus.tx_start); end
        total++; if (bus.req_ready !== '0)   begin bad++; $display("FAIL single_ready_width got=%b want=0", bus.req_ready); end
        while (cyc < s + busy_len + 1) tick();
        total++; if (bus.grant_valid !== 1'b1) begin bad++; $display("FAIL single_gv_hold got=%b want=1", bus.grant_valid); end
        total++; if (bus.tx_data !== 8'hA5)    begin bad++; $display("FAIL single_data_stable got=%h want=a5", bus.tx_data); end
        tick();
        total++; if (bus.grant_valid !== 1'b0) begin bad++; $display("FAIL single_gv_drop got=%b want=0", bus.grant_valid); end
    endtask

    task automatic test_fairness();
        int n, w, last;
        busy_en = 1'b1; busy_len = 40;
        v_now = '1;
        for (int i = 0; i < NR; i++) d_now[i] = DL'($urandom);
        do_reset();
        last = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!bus.tx_start && n < 200) begin tick(); n++; end
            total++; if (n >= 200) begin bad++; $display("FAIL fair_no_start got=none want=start k=%0d", k); end
            w = rr_pick(mptr, v_prev);
            total++; if (bus.grant_id !== w[1:0])        begin bad++; $display("FAIL fair_grant got=%0d want=%0d", bus.grant_id, w); end
            total++; if (bus.tx_data !== d_prev[w])      begin bad++; $display("FAIL fair_data got=%h want=%h", bus.tx_data, d_prev[w]); end
            total++; if (bus.req_ready !== NR'(1) << w)  begin bad++; $display("FAIL fair_ready got=%b want_idx=%0d", bus.req_ready, w); end
            if (k > 0) begin
                total++; if (cyc - last != 3 + busy_len + GAP) begin bad++; $display("FAIL fair_spacing got=%0d want=%0d", cyc - last, 3 + busy_len + GAP); end
            end
            last     = cyc;
            mptr     = (w + 1) % NR;
            d_now[w] = DL'($urandom);
            tick();
            total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL fair_start_width got=%b want=0", bus.tx_start); end
        end
        v_now = '0;
    endtask

    task automatic test_gap();
        int n, f, s1;
        bit seen_hi;
        busy_en = 1'b1; busy_len = 4 + int'($urandom_range(0, 11));
        v_now = 4'b0101;
        for (int i = 0; i < NR; i++) d_now[i] = DL'($urandom);
        do_reset();
        n = 0;
        while (!bus.tx_start && n < 100) begin tick(); n++; end
        s1 = cyc;
        d_now[0] = DL'($urandom);
        f = -1; seen_hi = 1'b0; n = 0;
        do begin
            tick(); n++;
            if (bus.tx_busy) seen_hi = 1'b1;
            else if (seen_hi && f < 0) f = cyc;
        end while (!bus.tx_start && n < 200);
        total++; if (cyc != f + GAP + 2)                 begin bad++; $display("FAIL gap_after_busy got=%0d want=%0d", cyc - f, GAP + 2); end
        total++; if (cyc - s1 != 3 + busy_len + GAP)     begin bad++; $display("FAIL gap_spacing got=%0d want=%0d", cyc - s1, 3 + busy_len + GAP); end
        total++; if (bus.grant_id !== 2'd2)              begin bad++; $display("FAIL gap_grant got=%0d want=2", bus.grant_id); end
        v_now = '0;
    endtask

    task automatic test_timeout();
        int n, s, r, r2, target;
        busy_en = 1'b0; v_now = '0;
        do_reset();
        r = int'($urandom_range(0, NR - 1));
        v_now[r] = 1'b1; d_now[r] = DL'($urandom);
        n = 0;
        while (!bus.tx_start && n < 50) begin tick(); n++; end
        s = cyc;
        total++; if (bus.grant_id !== r[1:0]) begin bad++; $display("FAIL tmo_first_grant got=%0d want=%0d", bus.grant_id, r); end
        mptr = (r + 1) % NR;
        v_now[r] = 1'b0;
        r2 = int'($urandom_range(0, NR - 1));
        v_now[r2] = 1'b1; d_now[r2] = DL'($urandom);
        target = s + TMO + GAP + 2;
        while (cyc < target) begin
            tick();
            if (cyc == s + 1) busy_en = 1'b1;
            total++; if (bus.timeout_err !== (cyc == s + 1 + TMO)) begin bad++; $display("FAIL tmo_pulse got=%b at=%0d want_at=%0d", bus.timeout_err, cyc - s, 1 + TMO); end
            total++; if (bus.tx_start !== (cyc == target))         begin bad++; $display("FAIL tmo_restart got=%b at=%0d want_at=%0d", bus.tx_start, cyc - s, target - s); end
            if (cyc == s + TMO) begin
                total++; if (bus.grant_valid !== 1'b1) begin bad++; $display("FAIL tmo_gv_hold got=%b want=1", bus.grant_valid); end
            end
            if (cyc == s + TMO + 1) begin
                total++; if (bus.grant_valid !== 1'b0) begin bad++; $display("FAIL tmo_gv_drop got=%b want=0", bus.grant_valid); end
            end
        end
        total++; if (bus.grant_id !== r2[1:0])     begin bad++; $display("FAIL tmo_next_grant got=%0d want=%0d", bus.grant_id, r2); end
        total++; if (bus.tx_data !== d_prev[r2])   begin bad++; $display("FAIL tmo_next_data got=%h want=%h", bus.tx_data, d_prev[r2]); end
        v_now = '0;
    endtask

    task automatic test_withdraw();
        int n, s, rdy;
        bit saw1;
        busy_en = 1'b1; busy_len = 8;
        v_now = 4'b1011;
        for (int i = 0; i < NR; i++) d_now[i] = DL'($urandom);
        do_reset();
        n = 0;
        while (!bus.tx_start && n < 50) begin tick(); n++; end
        s = cyc;
        total++; if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL wd_first_grant got=%0d want=0", bus.grant_id); end
        v_now[0] = 1'b0;
        rdy  = s + 3 + busy_len + GAP;
        saw1 = 1'b0;
        while (cyc < rdy) begin
            if (cyc == rdy - 2) v_now[1] = 1'b0;
            tick();
            saw1 |= bus.req_ready[1];
            total++; if (bus.tx_start !== (cyc == rdy)) begin bad++; $display("FAIL wd_start got=%b at=%0d want_at=%0d", bus.tx_start, cyc - s, rdy - s); end
        end
        total++; if (bus.grant_id !== 2'd3)     begin bad++; $display("FAIL wd_grant got=%0d want=3", bus.grant_id); end
        total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL wd_ready got=%b want=1000", bus.req_ready); end
        v_now[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); saw1 |= bus.req_ready[1]; end
        total++; if (saw1 !== 1'b0) begin bad++; $display("FAIL wd_ready1 got=%b want=0", saw1); end
    endtask

    task automatic test_reset_mid();
        int n, s;
        busy_en = 1'b1; busy_len = 20;
        v_now = 4'b0001; d_now[0] = DL'($urandom);
        do_reset();
        n = 0;
        while (!bus.tx_start && n < 50) begin tick(); n++; end
        s = cyc;
        v_now = 4'b0011; d_now[0] = DL'($urandom); d_now[1] = DL'($urandom);
        while (cyc < s + 5) tick();
        reset = 1'b1;
        tick();
        total++; if (bus.tx_start !== 1'b0)    begin bad++; $display("FAIL mid_tx_start got=%b want=0", bus.tx_start); end
        total++; if (bus.req_ready !== '0)     begin bad++; $display("FAIL mid_req_ready got=%b want=0", bus.req_ready); end
        total++; if (bus.tx_data !== '0)       begin bad++; $display("FAIL mid_tx_data got=%h want=0", bus.tx_data); end
        total++; if (bus.grant_id !== '0)      begin bad++; $display("FAIL mid_grant_id got=%0d want=0", bus.grant_id); end
        total++; if (bus.grant_valid !== 1'b0) begin bad++; $display("FAIL mid_grant_valid got=%b want=0", bus.grant_valid); end
        total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL mid_timeout_err got=%b want=0", bus.timeout_err); end
        reset = 1'b0;
        tick();
        total++; if (bus.tx_start !== 1'b1)     begin bad++; $display("FAIL mid_regrant got=%b want=1", bus.tx_start); end
        total++; if (bus.grant_id !== 2'd0)     begin bad++; $display("FAIL mid_grant_low got=%0d want=0", bus.grant_id); end
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ready got=%b want=0001", bus.req_ready); end
        total++; if (bus.tx_data !== d_prev[0]) begin bad++; $display("FAIL mid_data got=%h want=%h", bus.tx_data, d_prev[0]); end
        v_now = '0;
    endtask

    task automatic test_random();
        int  w;
        bit  exp_start;
        busy_en = 1'b1; v_now = '0;
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < NR; i++) begin
                if (!v_now[i] && $urandom_range(0, 7) == 0) begin
                    v_now[i] = 1'b1; d_now[i] = DL'($urandom);
                end else if (v_now[i] && $urandom_range(0, 31) == 0) begin
                    v_now[i] = 1'b0;
                end
            end
            tick();
            exp_start = (cyc >= ready_at) && (v_prev != '0);
            total++; if (bus.tx_start !== exp_start) begin bad++; $display("FAIL rnd_start got=%b want=%b cyc=%0d", bus.tx_start, exp_start, cyc); end
            if (exp_start) begin
                w = rr_pick(mptr, v_prev);
                total++; if (bus.grant_id !== w[1:0])       begin bad++; $display("FAIL rnd_grant got=%0d want=%0d", bus.grant_id, w); end
                total++; if (bus.req_ready !== NR'(1) << w) begin bad++; $display("FAIL rnd_ready got=%b want_idx=%0d", bus.req_ready, w); end
                txd      = d_prev[w];
                mptr     = (w + 1) % NR;
                busy_len = int'($urandom_range(1, 14));
                ready_at = cyc + 3 + busy_len + GAP;
                if ($urandom_range(0, 1) == 0) v_now[w] = 1'b0;
                else                           d_now[w] = DL'($urandom);
            end else begin
                total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL rnd_idle_ready got=%b want=0", bus.req_ready); end
            end
            total++; if (bus.tx_data !== txd)      begin bad++; $display("FAIL rnd_data got=%h want=%h", bus.tx_data, txd); end
            total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL rnd_timeout got=%b want=0", bus.timeout_err); end
        end
        v_now = '0;
    endtask

    initial begin
        reset = 1'b1;
        v_now = '0;
        for (int i = 0; i < NR; i++) d_now[i] = '0;
        test_reset();
        test_single();
        test_fairness();
        test_gap();
        test_timeout();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
